// File: rtl/mbist_pkg.sv
// Shared encodings for the March C- BIST controller: FSM states, memory op codes
// and the six-element March C- table.
package mbist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ELEM_START,
        ST_OP,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_W0,
        OP_W1,
        OP_R0,
        OP_R1
    } op_e;

    typedef struct packed {
        logic       dir_up;
        logic [1:0] nops;
        op_e        op0;
        op_e        op1;
    } elem_t;

    localparam logic [2:0] LAST_ELEM = 3'd5;

    function automatic elem_t march_elem(input logic [2:0] idx);
        elem_t e;
        case (idx)
            3'd0:    e = '{dir_up: 1'b1, nops: 2'd1, op0: OP_W0, op1: OP_NOP};
            3'd1:    e = '{dir_up: 1'b1, nops: 2'd2, op0: OP_R0, op1: OP_W1};
            3'd2:    e = '{dir_up: 1'b1, nops: 2'd2, op0: OP_R1, op1: OP_W0};
            3'd3:    e = '{dir_up: 1'b0, nops: 2'd2, op0: OP_R0, op1: OP_W1};
            3'd4:    e = '{dir_up: 1'b0, nops: 2'd2, op0: OP_R1, op1: OP_W0};
            3'd5:    e = '{dir_up: 1'b1, nops: 2'd1, op0: OP_R0, op1: OP_NOP};
            default: e = '{dir_up: 1'b1, nops: 2'd1, op0: OP_NOP, op1: OP_NOP};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/mbist_rdcmp.sv
// Read-compare pipeline: captures expected data with the read strobe, compares the
// returning data one cycle later and latches the first mismatch.
module mbist_rdcmp #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_exp,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [2:0]            rd_elem,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem
);

    logic                  pend_q;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            elem_q;
    logic                  fail_q, fail_d;
    logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
    logic [2:0]            felem_q, felem_d;

    // Only the first mismatch is recorded; fail stays set until cleared.
    always_comb begin
        fail_d  = fail_q;
        faddr_d = faddr_q;
        felem_d = felem_q;
        if (pend_q && (rdata != exp_q) && !fail_q) begin
            fail_d  = 1'b1;
            faddr_d = addr_q;
            felem_d = elem_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            pend_q  <= 1'b0;
            exp_q   <= '0;
            addr_q  <= '0;
            elem_q  <= '0;
            fail_q  <= 1'b0;
            faddr_q <= '0;
            felem_q <= '0;
        end else begin
            pend_q  <= rd_en;
            exp_q   <= rd_exp;
            addr_q  <= rd_addr;
            elem_q  <= rd_elem;
            fail_q  <= fail_d;
            faddr_q <= faddr_d;
            felem_q <= felem_d;
        end
    end

    assign fail      = fail_q;
    assign fail_addr = faddr_q;
    assign fail_elem = felem_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST sequencer driving an external address generator and RAM,
// with registered read compare and first-fail capture.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  sweep_done,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  start_elem,
    output logic                  dir_up,
    output logic                  addr_step,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem
);

    state_e     state_q, state_d;
    logic [2:0] elem_q, elem_d;
    logic       op_q, op_d;
    logic       sweep_q, sweep_d;
    logic       clr;

    elem_t cur;
    op_e   cur_op;
    logic  last_op, at_end, noop, in_op;

    assign cur     = march_elem(elem_q);
    assign cur_op  = op_q ? cur.op1 : cur.op0;
    assign last_op = ({1'b0, op_q} == (cur.nops - 2'd1));
    assign at_end  = cur.dir_up ? (addr == {ADDR_WIDTH{1'b1}}) : (addr == '0);
    // sweep_q mirrors the generator's sweep_done from our own step history, so the
    // post-sweep idle cycle is decoded from registers rather than from the input.
    assign noop    = !op_q && sweep_q;
    assign in_op   = (state_q == ST_OP) && !noop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            elem_q  <= '0;
            op_q    <= 1'b0;
            sweep_q <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            op_q    <= op_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        op_d    = op_q;
        sweep_d = sweep_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_ELEM_START;
                    elem_d  = '0;
                    op_d    = 1'b0;
                    sweep_d = 1'b0;
                    clr     = 1'b1;
                end
            end
            ST_ELEM_START: begin
                state_d = ST_OP;
                op_d    = 1'b0;
                sweep_d = 1'b0;
            end
            ST_OP: begin
                if (!op_q && sweep_done) begin
                    if (elem_q == LAST_ELEM) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ELEM_START;
                        elem_d  = elem_q + 3'd1;
                    end
                end else if (!noop) begin
                    if (last_op) begin
                        op_d = 1'b0;
                        if (at_end) sweep_d = 1'b1;
                    end else begin
                        op_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start_elem = (state_q == ST_ELEM_START);
        busy       = (state_q == ST_ELEM_START) || (state_q == ST_OP) || (state_q == ST_DRAIN);
        done       = (state_q == ST_DONE);
        dir_up     = ((state_q == ST_IDLE) || (state_q == ST_DONE)) ? 1'b1 : cur.dir_up;
        mem_we     = in_op && ((cur_op == OP_W0) || (cur_op == OP_W1));
        mem_re     = in_op && ((cur_op == OP_R0) || (cur_op == OP_R1));
        mem_wdata  = (in_op && (cur_op == OP_W1)) ? {DATA_WIDTH{1'b1}} : '0;
        addr_step  = in_op && last_op;
    end

    mbist_rdcmp #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rdcmp (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .rd_en     (mem_re),
        .rd_exp    ({DATA_WIDTH{cur_op == OP_R1}}),
        .rd_addr   (addr),
        .rd_elem   (elem_q),
        .rdata     (mem_rdata),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem)
    );

endmodule

// File: doc/mbist_march_ctrl.md
MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, the memory address width; N = 2^ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the memory word width.
REQ-003 SHALL have one clock and a synchronous active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-004 SHALL have: start  input  1  begin test, sampled in IDLE or DONE only.
REQ-005 SHALL have: sweep_done  input  1  from address generator, high after the last-address step.
REQ-006 SHALL have: addr  input  ADDR_WIDTH  current address from address generator.
REQ-007 SHALL have: mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after mem_re.
REQ-008 SHALL have: start_elem / dir_up / addr_step  output  1 each  address generator controls (dir_up 1 = ascending).
REQ-009 SHALL have: mem_we, mem_re  output  1  memory write/read strobes; mem_wdata  output  DATA_WIDTH  write data.
REQ-010 SHALL have: busy, done, fail  output  1; fail_addr  output  ADDR_WIDTH; fail_elem  output  3.

Function
REQ-011 SHALL execute March C-: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0); "0" = all-zeros word, "1" = all-ones word.
REQ-012 SHALL use states IDLE, ELEM_START, OP, DRAIN, DONE, with a 3-bit element index and a 1-bit op index.
REQ-013 IDLE/DONE + start=1 -> ELEM_START with element 0; start in any other state SHALL be ignored.
REQ-014 ELEM_START SHALL last one cycle, assert start_elem=1 with dir_up from the element table, then enter OP with op index 0.
REQ-015 OP, op index 0, sweep_done=1: no memory op; go to ELEM_START of the next element, or to DRAIN after M5.
REQ-016 OP, otherwise: assert the table op (mem_we with mem_wdata, or mem_re), one op per cycle.
REQ-017 addr_step SHALL be asserted only in the cycle of an element's final op; op index then returns to 0, else it increments.
REQ-018 start_elem, dir_up, addr_step, mem_we, mem_re, mem_wdata and busy SHALL be decoded from state registers only, with no combinational input-to-output path.
REQ-019 Read compare: expected data and addr SHALL be registered with mem_re; mem_rdata SHALL be compared in the next cycle, and a mismatch SHALL set fail in the cycle after that.
REQ-020 fail SHALL be sticky; fail_addr/fail_elem SHALL capture the first mismatch only; later mismatches SHALL leave them unchanged.
REQ-021 DRAIN SHALL last one cycle so the final M5 compare completes, then enter DONE.
REQ-022 busy=1 in ELEM_START/OP/DRAIN; done=1 only in DONE, held until a new start.
REQ-023 A new start from DONE SHALL clear fail, fail_addr and fail_elem in the ELEM_START cycle.
REQ-024 Cycle budget: done SHALL rise exactly 10N+13 cycles after the first ELEM_START cycle.
REQ-025 Element-table direction SHALL be applied on each start_elem; dir_up SHALL be 1 in IDLE/DONE.

Reset
REQ-026 reset=1 at any clock edge, including mid-test, SHALL force IDLE, element/op index 0, and the compare pipeline empty.
REQ-027 Reset values: start_elem=0, addr_step=0, dir_up=1, mem_we=0, mem_re=0, mem_wdata=0, busy=0, done=0, fail=0, fail_addr=0, fail_elem=0.
REQ-028 A read issued before reset SHALL NOT set fail after reset.

Structure
REQ-029 Package mbist_pkg SHALL hold the state encoding, the op encoding (NOP/W0/W1/R0/R1) and the six-entry March C- element table (direction, op count, op0, op1).
REQ-030 The read-compare pipeline and first-fail capture SHALL be a sub-module, mbist_rdcmp.

Verification
REQ-031 Fault-free RAM model + address generator, ADDR_WIDTH=2: start -> done rises 53 cycles after ELEM_START, fail=0, 40 memory ops total.
REQ-032 Stuck-at-1 on bit 0 at address 2, ADDR_WIDTH=2: -> fail=1, fail_addr=2, fail_elem=1; no update on later mismatches.
REQ-033 Read-data mismatch only on the final M5 read at address 3 -> fail=1 set during DRAIN/DONE, fail_addr=3, fail_elem=5.
REQ-034 reset pulsed mid-M3 -> next cycle IDLE, all outputs at reset values; a new start completes fault-free run per REQ-031.
REQ-035 start held high throughout the run -> no restart until DONE; start in DONE clears fail and reruns.
REQ-036 Monitor: mem_we and mem_re never both 1; start_elem only in ELEM_START; dir_up=0 exactly during M3/M4 ops.
